// File: rtl/alu_mdu.sv
// Combinational integer ALU plus multi-cycle multiply/divide unit with HI/LO registers.
// Define ALU_MDU_MADD_EN to add signed MADD/MSUB accumulation into {hi,lo} (md_op 6/7).
module alu_mdu #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu1,
  input  logic [WIDTH-1:0] alu2,
  input  logic [3:0]       ALUop,
  input  logic [2:0]       md_op,
  input  logic             start,
  output logic [WIDTH-1:0] aluout,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned SHW  = $clog2(WIDTH);
  localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = $clog2(MAXC + 1);
  localparam int unsigned DW   = 2 * WIDTH;

  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MSUB  = 3'd7
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // ---------------------------------------------------------------- ALU
  logic [SHW-1:0] shamt;
  assign shamt = alu2[SHW-1:0];

  always_comb begin : alu_comb
    aluout = '0;
    case (ALUop)
      ALU_AND:  aluout = alu1 & alu2;
      ALU_OR:   aluout = alu1 | alu2;
      ALU_ADD:  aluout = alu1 + alu2;
      ALU_SUB:  aluout = alu1 - alu2;
      ALU_XOR:  aluout = alu1 ^ alu2;
      ALU_NOR:  aluout = ~(alu1 | alu2);
      ALU_SLT:  aluout = {{(WIDTH-1){1'b0}}, ($signed(alu1) < $signed(alu2))};
      ALU_SLTU: aluout = {{(WIDTH-1){1'b0}}, (alu1 < alu2)};
      ALU_SLL:  aluout = alu1 << shamt;
      ALU_SRL:  aluout = alu1 >> shamt;
      ALU_SRA:  aluout = WIDTH'($signed(alu1) >>> shamt);
      ALU_LUI:  aluout = alu2 << (WIDTH / 2);
      default:  aluout = '0;
    endcase
  end

  // ---------------------------------------------------------------- MDU state
  state_e           state_q, state_d;
  md_op_e           op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             op_is_div, op_signed, a_neg, b_neg, div_zero, done, launch;
  logic [WIDTH-1:0] dvd, dvs, uq, ur, quo, rem;
  logic [DW-1:0]    prod_u, prod_s, result;

  // Result datapath from latched operands; sampled only on the completion edge.
  // Signed division runs on magnitudes so MIN/-1 folds out to lo=MIN, hi=0.
  always_comb begin : mdu_datapath
    op_is_div = (op_q == MD_DIV) || (op_q == MD_DIVU);
    op_signed = (op_q != MD_MULTU) && (op_q != MD_DIVU);
    a_neg     = op_signed & a_q[WIDTH-1];
    b_neg     = op_signed & b_q[WIDTH-1];
    div_zero  = (b_q == '0);
    dvd       = a_neg ? -a_q : a_q;
    dvs       = b_neg ? -b_q : (div_zero ? WIDTH'(1) : b_q);
    uq        = dvd / dvs;
    ur        = dvd % dvs;
    quo       = (a_neg ^ b_neg) ? -uq : uq;
    rem       = a_neg ? -ur : ur;
    if (div_zero) begin
      quo = '1;
      rem = a_q;
    end
    prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    result = {hi_q, lo_q};
    case (op_q)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV,
      MD_DIVU:  result = {rem, quo};
`ifdef ALU_MDU_MADD_EN
      MD_MADD:  result = {hi_q, lo_q} + prod_s;
      MD_MSUB:  result = {hi_q, lo_q} - prod_s;
`endif
      default:  result = {hi_q, lo_q};
    endcase
  end

  // Next-state: accept only while idle; HI/LO change only on MTHI/MTLO or completion.
  always_comb begin : mdu_next
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    launch  = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: launch = 1'b1;
`ifdef ALU_MDU_MADD_EN
            MD_MADD, MD_MSUB:                   launch = 1'b1;
`endif
            MD_MTHI:                            hi_d = alu1;
            MD_MTLO:                            lo_d = alu1;
            default:                            launch = 1'b0;
          endcase
        end
        if (launch) begin
          op_d    = md_op_e'(md_op);
          a_d     = alu1;
          b_d     = alu2;
          cnt_d   = CW'(1);
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        done = (cnt_q == (op_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)));
        if (done) begin
          {hi_d, lo_d} = result;
          cnt_d        = '0;
          busy_d       = 1'b0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin : mdu_regs
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULT;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: random and directed stimulus against an arithmetic model.
// Exercises MADD/MSUB when compiled with ALU_MDU_MADD_EN, otherwise checks md_op 6/7 as no-ops.
module tb_alu_mdu;

  localparam int unsigned W  = 32;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic         clk   = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] alu1  = '0;
  logic [W-1:0] alu2  = '0;
  logic [3:0]   ALUop = '0;
  logic [2:0]   md_op = '0;
  logic         start = 1'b0;
  logic [W-1:0] aluout, hi, lo;
  logic         busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Architectural HI/LO as the model expects them after every completed operation.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_mdu #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk    (clk),
    .reset  (reset),
    .alu1   (alu1),
    .alu2   (alu2),
    .ALUop  (ALUop),
    .md_op  (md_op),
    .start  (start),
    .aluout (aluout),
    .busy   (busy),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] alu_ref(input logic [3:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    logic [W-1:0] r;
    int signed    sa, sb;
    int unsigned  sh;
    sa = $signed(a);
    sb = $signed(b);
    sh = int'(b % 32);
    case (op)
      4'd0:    r = a & b;
      4'd1:    r = a | b;
      4'd2:    r = a + b;
      4'd3:    r = a - b;
      4'd4:    r = a ^ b;
      4'd5:    r = ~(a | b);
      4'd6:    r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7:    r = (a < b) ? 32'd1 : 32'd0;
      4'd8:    r = a << sh;
      4'd9:    r = a >> sh;
      4'd10:   r = 32'(sa >>> sh);
      4'd11:   r = b * 32'd65536;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic void model_mdu(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    case (op)
      3'd0: {m_hi, m_lo} = 64'(sa * sb);
      3'd1: {m_hi, m_lo} = ua * ub;
      3'd2: if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
      3'd3: if (b == 0) begin m_lo = '1; m_hi = a; end
            else begin m_lo = a / b; m_hi = a % b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
`ifdef ALU_MDU_MADD_EN
      3'd6: {m_hi, m_lo} = {m_hi, m_lo} + 64'(sa * sb);
      3'd7: {m_hi, m_lo} = {m_hi, m_lo} - 64'(sa * sb);
`endif
      default: ;
    endcase
  endfunction

  // One-cycle start strobe; returns at the falling edge of the first cycle after acceptance.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    alu1  = a;
    alu2  = b;
    md_op = op;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_hold: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    else n_pass++;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0})
      $display("FAIL reset_release: busy=%b hi=%h lo=%h, want 0/0/0", busy, hi, lo);
    else n_pass++;
    m_hi = '0;
    m_lo = '0;
  endtask

  task automatic test_alu();
    logic [3:0]   dop [4] = '{4'd3, 4'd6, 4'd7, 4'd10};
    logic [W-1:0] da  [4] = '{32'd5, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [W-1:0] db  [4] = '{32'd7, 32'd7, 32'd1, 32'd4};
    logic [W-1:0] dex [4] = '{32'hFFFF_FFFE, 32'd1, 32'd0, 32'hF800_0000};
    logic [W-1:0] exp_v;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ALUop = dop[i]; alu1 = da[i]; alu2 = db[i];
      #1;
      n_checks++;
      if (aluout !== dex[i])
        $display("FAIL alu_directed[%0d] op=%0d: got %h, want %h", i, dop[i], aluout, dex[i]);
      else n_pass++;
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ALUop = 4'(i % 16);
      alu1  = $urandom;
      alu2  = (i % 3 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      exp_v = alu_ref(ALUop, alu1, alu2);
      #1;
      n_checks++;
      if (aluout !== exp_v)
        $display("FAIL alu_random op=%0d a=%h b=%h: got %h, want %h", ALUop, alu1, alu2, aluout, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_mtx();
    logic [W-1:0] v;
    model_mdu(3'd5, 32'h1234, 32'h0);
    issue(3'd5, 32'h1234, $urandom);
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, 32'h1234})
        $display("FAIL mtlo cyc %0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=00001234",
                 c, busy, hi, lo, m_hi);
      else n_pass++;
      @(negedge clk);
    end
    v = $urandom;
    model_mdu(3'd4, v, 32'h0);
    issue(3'd4, v, $urandom);
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
      $display("FAIL mthi: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h", busy, hi, lo, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_mult();
    for (int i = 0; i < 8; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b, old_hi, old_lo;
      case (i)
        0:       begin op = 3'd0; a = 32'hFFFF_FFFD; b = 32'd7; end
        1:       begin op = 3'd1; a = 32'hFFFF_FFFF; b = 32'd2; end
        default: begin op = 3'($urandom_range(0, 1)); a = $urandom; b = $urandom; end
      endcase
      old_hi = m_hi; old_lo = m_lo;
      model_mdu(op, a, b);
      issue(op, a, b);
      for (int c = 0; c < int'(MC); c++) begin
        n_checks++;
        if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
          $display("FAIL mult_busy[%0d] cyc %0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                   i, c + 1, busy, hi, lo, old_hi, old_lo);
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
        $display("FAIL mult_result[%0d] op=%0d %h*%h: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 i, op, a, b, busy, hi, lo, m_hi, m_lo);
      else n_pass++;
    end
  endtask

  task automatic test_div();
    for (int i = 0; i < 12; i++) begin
      logic [2:0]   op;
      logic [W-1:0] a, b, old_hi, old_lo;
      case (i)
        0:       begin op = 3'd2; a = 32'hFFFF_FFF9; b = 32'd2; end
        1:       begin op = 3'd3; a = 32'd9; b = 32'd0; end
        2:       begin op = 3'd2; a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3:       begin op = 3'd2; a = 32'hFFFF_FF00; b = 32'd0; end
        default: begin
          op = 3'($urandom_range(2, 3));
          a  = $urandom;
          b  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
          if (i % 2 == 0 && (i % 4) == 0) b = -b;
        end
      endcase
      old_hi = m_hi; old_lo = m_lo;
      model_mdu(op, a, b);
      issue(op, a, b);
      for (int c = 0; c < int'(DC); c++) begin
        n_checks++;
        if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
          $display("FAIL div_busy[%0d] cyc %0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                   i, c + 1, busy, hi, lo, old_hi, old_lo);
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
        $display("FAIL div_result[%0d] op=%0d %h/%h: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 i, op, a, b, busy, hi, lo, m_hi, m_lo);
      else n_pass++;
    end
  endtask

  task automatic test_start_while_busy();
    logic [W-1:0] a, b, old_hi, old_lo;
    a = $urandom; b = $urandom;
    old_hi = m_hi; old_lo = m_lo;
    model_mdu(3'd0, a, b);
    issue(3'd0, a, b);
    for (int c = 0; c < int'(MC); c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
        $display("FAIL drop_busy cyc %0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                 c + 1, busy, hi, lo, old_hi, old_lo);
      else n_pass++;
      md_op = (c % 2 == 0) ? 3'd3 : 3'(3 + c % 3);
      alu1  = $urandom;
      alu2  = $urandom;
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
        $display("FAIL drop_result cyc %0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 c, busy, hi, lo, m_hi, m_lo);
      else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a, b, old_hi, old_lo;
    a = $urandom; b = $urandom;
    old_hi = m_hi; old_lo = m_lo;
    model_mdu(3'd1, a, b);
    issue(3'd1, a, b);
    for (int c = 0; c < int'(MC); c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
        $display("FAIL b2b_mult_busy cyc %0d: busy=%b hi=%h lo=%h", c + 1, busy, hi, lo);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
      $display("FAIL b2b_mult_result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
               busy, hi, lo, m_hi, m_lo);
    else n_pass++;
    // Start the divide in the very first idle cycle.
    a = $urandom; b = 32'($urandom_range(1, 1000));
    old_hi = m_hi; old_lo = m_lo;
    model_mdu(3'd3, a, b);
    alu1 = a; alu2 = b; md_op = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < int'(DC); c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
        $display("FAIL b2b_div_busy cyc %0d: busy=%b hi=%h lo=%h, want busy=1 hi=%h lo=%h",
                 c + 1, busy, hi, lo, old_hi, old_lo);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
      $display("FAIL b2b_div_result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
               busy, hi, lo, m_hi, m_lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] a, b;
    issue(3'd4, 32'hA5A5_5A5A, 32'h0);
    issue(3'd5, 32'h0F0F_F0F0, 32'h0);
    issue(3'd2, 32'h0000_1000, 32'd3);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    for (int c = 0; c < int'(DC); c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, 32'h0, 32'h0})
        $display("FAIL reset_abort cyc %0d: busy=%b hi=%h lo=%h, want 0/0/0", c, busy, hi, lo);
      else n_pass++;
      @(negedge clk);
    end
    a = $urandom; b = $urandom;
    model_mdu(3'd0, a, b);
    issue(3'd0, a, b);
    for (int c = 0; c < int'(MC); c++) begin
      n_checks++;
      if ({busy, hi, lo} !== {1'b1, 32'h0, 32'h0})
        $display("FAIL reset_mult_busy cyc %0d: busy=%b hi=%h lo=%h", c + 1, busy, hi, lo);
      else n_pass++;
      @(negedge clk);
    end
    n_checks++;
    if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
      $display("FAIL reset_mult_result: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
               busy, hi, lo, m_hi, m_lo);
    else n_pass++;
  endtask

`ifdef ALU_MDU_MADD_EN
  task automatic test_optional();
    logic [2:0]   ops [6] = '{3'd6, 3'd7, 3'd6, 3'd7, 3'd6, 3'd7};
    logic [W-1:0] old_hi, old_lo, a, b;
    issue(3'd4, 32'd0, 32'd0);
    issue(3'd5, 32'd10, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd10;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       begin a = 32'd3; b = 32'd4; end
        1:       begin a = 32'd5; b = 32'd5; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      old_hi = m_hi; old_lo = m_lo;
      model_mdu(ops[i], a, b);
      issue(ops[i], a, b);
      for (int c = 0; c < int'(MC); c++) begin
        n_checks++;
        if ({busy, hi, lo} !== {1'b1, old_hi, old_lo})
          $display("FAIL madd_busy[%0d] cyc %0d: busy=%b hi=%h lo=%h", i, c + 1, busy, hi, lo);
        else n_pass++;
        @(negedge clk);
      end
      n_checks++;
      if ({busy, hi, lo} !== {1'b0, m_hi, m_lo})
        $display("FAIL madd_result[%0d] op=%0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                 i, ops[i], busy, hi, lo, m_hi, m_lo);
      else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFD)
          $display("FAIL msub_directed: hi=%h lo=%h, want hi=ffffffff lo=fffffffd", hi, lo);
        else n_pass++;
      end
    end
  endtask
`else
  task automatic test_optional();
    logic [W-1:0] old_hi, old_lo;
    for (int i = 6; i < 8; i++) begin
      old_hi = m_hi; old_lo = m_lo;
      model_mdu(3'(i), 32'h0, 32'h0);
      issue(3'(i), $urandom, $urandom);
      for (int c = 0; c < 2; c++) begin
        n_checks++;
        if ({busy, hi, lo} !== {1'b0, old_hi, old_lo})
          $display("FAIL invalid_op%0d cyc %0d: busy=%b hi=%h lo=%h, want busy=0 hi=%h lo=%h",
                   i, c, busy, hi, lo, old_hi, old_lo);
        else n_pass++;
        @(negedge clk);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_mtx();
    test_mult();
    test_div();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_op();
    test_optional();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
